// File: rtl/video_timing_gen_if.sv
// Video timing bus between the raster generator and the core/video path.
// The master modport is the timing generator; the slave modport is the core/scaler side.
interface video_timing_gen_if #(
  parameter int RGB_W = 12,
  parameter int POS_W = 9
);
  logic                    ce_pix;
  logic signed [3:0]       h_adj;
  logic signed [2:0]       v_adj;
  logic [RGB_W-1:0]        iRGB;
  logic [POS_W-1:0]        HPOS;
  logic [POS_W-1:0]        VPOS;
  logic [RGB_W-1:0]        oRGB;
  logic                    HBLK;
  logic                    VBLK;
  logic                    HSYN;
  logic                    VSYN;
  logic                    line_start;
  logic                    frame_start;
  logic                    field;

  modport master (
    input  ce_pix, h_adj, v_adj, iRGB,
    output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, line_start, frame_start, field
  );

  modport slave (
    output ce_pix, h_adj, v_adj, iRGB,
    input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, line_start, frame_start, field
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V counters, blanking, adjustable sync,
// line/frame strobes and optional interlace field toggling.
module video_timing_gen #(
  parameter int RGB_W        = 12,
  parameter int POS_W        = 9,
  parameter int H_TOTAL      = 384,
  parameter int H_ACT_START  = 16,
  parameter int H_ACT_LEN    = 256,
  parameter int H_SYNC_START = 312,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_TOTAL      = 263,
  parameter int V_ACT_START  = 16,
  parameter int V_ACT_LEN    = 192,
  parameter int V_SYNC_START = 236,
  parameter int V_SYNC_LEN   = 7,
  parameter int INTERLACE    = 0
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  video_timing_gen_if.master vif
);

  if (H_ACT_START + H_ACT_LEN > H_TOTAL) begin : g_err_hact
    $error("video_timing_gen: H active region exceeds H_TOTAL");
  end
  if (H_SYNC_LEN >= H_TOTAL) begin : g_err_hsync
    $error("video_timing_gen: H_SYNC_LEN must be below H_TOTAL");
  end
  if (H_TOTAL > (1 << POS_W)) begin : g_err_hwidth
    $error("video_timing_gen: H_TOTAL does not fit in POS_W");
  end
  if (V_ACT_START + V_ACT_LEN > V_TOTAL) begin : g_err_vact
    $error("video_timing_gen: V active region exceeds V_TOTAL");
  end
  if (V_SYNC_LEN >= V_TOTAL) begin : g_err_vsync
    $error("video_timing_gen: V_SYNC_LEN must be below V_TOTAL");
  end
  if (V_TOTAL + INTERLACE > (1 << POS_W)) begin : g_err_vwidth
    $error("video_timing_gen: V_TOTAL does not fit in POS_W");
  end

  // Signed working width leaves headroom for start + adjust before the modulo fold.
  localparam int SW = POS_W + 3;
  typedef logic signed [SW-1:0] s_t;

  localparam s_t H_TOT_S = s_t'(H_TOTAL);
  localparam s_t H_AS_S  = s_t'(H_ACT_START);
  localparam s_t H_AE_S  = s_t'(H_ACT_START + H_ACT_LEN);
  localparam s_t H_SS_S  = s_t'(H_SYNC_START);
  localparam s_t H_SL_S  = s_t'(H_SYNC_LEN);
  localparam s_t V_TOT_S = s_t'(V_TOTAL);
  localparam s_t V_AS_S  = s_t'(V_ACT_START);
  localparam s_t V_AE_S  = s_t'(V_ACT_START + V_ACT_LEN);
  localparam s_t V_SS_S  = s_t'(V_SYNC_START);
  localparam s_t V_SL_S  = s_t'(V_SYNC_LEN);

  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST0  = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST1  = POS_W'(V_TOTAL);
  localparam logic [POS_W-1:0] H_AS_P   = POS_W'(H_ACT_START);
  localparam logic [POS_W-1:0] V_AS_P   = POS_W'(V_ACT_START);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic [POS_W-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d, v_last;
  logic              h_wrap, v_wrap;
  logic              field_q;
  logic signed [3:0] h_adj_q;
  logic signed [2:0] v_adj_q;
  s_t                hcnt_s, vcnt_s, hs0, vs0, hdiff, vdiff;
  logic              hblk_d, vblk_d, hsyn_d, vsyn_d;
  logic [RGB_W-1:0]  rgb_d;
  logic              hblk_q, vblk_q, hsyn_q, vsyn_q, ls_q, fs_q;
  logic [RGB_W-1:0]  rgb_q;

  always_comb begin
    h_wrap = (hcnt_q == H_LAST);
    v_last = ((INTERLACE != 0) && field_q) ? V_LAST1 : V_LAST0;
    v_wrap = (vcnt_q == v_last);
    hcnt_d = h_wrap ? '0 : hcnt_q + POS_ONE;
    vcnt_d = vcnt_q;
    if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + POS_ONE;

    hcnt_s = s_t'({3'b000, hcnt_q});
    vcnt_s = s_t'({3'b000, vcnt_q});

    // Fold the adjusted sync start back into [0, TOTAL) so the window can straddle 0.
    hs0 = H_SS_S + s_t'(h_adj_q);
    if (hs0[SW-1])          hs0 = hs0 + H_TOT_S;
    else if (hs0 >= H_TOT_S) hs0 = hs0 - H_TOT_S;
    vs0 = V_SS_S + s_t'(v_adj_q);
    if (vs0[SW-1])          vs0 = vs0 + V_TOT_S;
    else if (vs0 >= V_TOT_S) vs0 = vs0 - V_TOT_S;

    hdiff = hcnt_s - hs0;
    if (hdiff[SW-1]) hdiff = hdiff + H_TOT_S;
    vdiff = vcnt_s - vs0;
    if (vdiff[SW-1]) vdiff = vdiff + V_TOT_S;

    hsyn_d = !(hdiff < H_SL_S);
    vsyn_d = !(vdiff < V_SL_S);
    hblk_d = !((hcnt_s >= H_AS_S) && (hcnt_s < H_AE_S));
    vblk_d = !((vcnt_s >= V_AS_S) && (vcnt_s < V_AE_S));
    rgb_d  = (hblk_d || vblk_d) ? '0 : vif.iRGB;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      field_q <= 1'b0;
      h_adj_q <= '0;
      v_adj_q <= '0;
      hblk_q  <= 1'b1;
      vblk_q  <= 1'b1;
      hsyn_q  <= 1'b1;
      vsyn_q  <= 1'b1;
      rgb_q   <= '0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      if (vif.ce_pix) begin
        hcnt_q <= hcnt_d;
        vcnt_q <= vcnt_d;
        hblk_q <= hblk_d;
        vblk_q <= vblk_d;
        hsyn_q <= hsyn_d;
        vsyn_q <= vsyn_d;
        rgb_q  <= rgb_d;
        ls_q   <= h_wrap;
        fs_q   <= h_wrap && v_wrap;
        // Adjusts only take effect from a frame boundary to avoid tearing the sync.
        if (h_wrap && v_wrap) begin
          h_adj_q <= vif.h_adj;
          v_adj_q <= vif.v_adj;
          if (INTERLACE != 0) field_q <= !field_q;
        end
      end
    end
  end

  assign vif.HPOS        = hcnt_q - H_AS_P;
  assign vif.VPOS        = vcnt_q - V_AS_P;
  assign vif.oRGB        = rgb_q;
  assign vif.HBLK        = hblk_q;
  assign vif.VBLK        = vblk_q;
  assign vif.HSYN        = hsyn_q;
  assign vif.VSYN        = vsyn_q;
  assign vif.line_start  = ls_q;
  assign vif.frame_start = fs_q;
  assign vif.field       = field_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default geometry plus two reduced geometries
// (progressive and interlaced) so frame-level behaviour fits in a short run.
module tb_video_timing_gen;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  always #5 clk = ~clk;

  video_timing_gen_if #(.RGB_W(12), .POS_W(9)) if_a ();
  video_timing_gen_if #(.RGB_W(12), .POS_W(6)) if_b ();
  video_timing_gen_if #(.RGB_W(12), .POS_W(6)) if_c ();

  video_timing_gen u_a (.clk_sys(clk), .reset_n(rst_a), .vif(if_a));

  video_timing_gen #(
    .RGB_W(12), .POS_W(6), .H_TOTAL(20), .H_ACT_START(2), .H_ACT_LEN(12),
    .H_SYNC_START(15), .H_SYNC_LEN(3), .V_TOTAL(10), .V_ACT_START(1), .V_ACT_LEN(6),
    .V_SYNC_START(7), .V_SYNC_LEN(2), .INTERLACE(0)
  ) u_b (.clk_sys(clk), .reset_n(rst_b), .vif(if_b));

  video_timing_gen #(
    .RGB_W(12), .POS_W(6), .H_TOTAL(20), .H_ACT_START(2), .H_ACT_LEN(12),
    .H_SYNC_START(15), .H_SYNC_LEN(3), .V_TOTAL(10), .V_ACT_START(1), .V_ACT_LEN(6),
    .V_SYNC_START(7), .V_SYNC_LEN(2), .INTERLACE(1)
  ) u_c (.clk_sys(clk), .reset_n(rst_c), .vif(if_c));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         t;
    logic [11:0] rgb;
    int         hpos;
    int         vpos;
    logic       hblk;
    logic       vblk;
    logic       hsyn;
    logic       vsyn;
    logic       ls;
    logic [11:0] orgb;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ls_b(output int n);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (if_b.line_start) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic capture_line_b(output logic [19:0] hs_m, output logic [19:0] hb_m);
    hs_m = '0;
    hb_m = '0;
    hs_m[0] = !if_b.HSYN;
    hb_m[0] = !if_b.HBLK;
    for (int k = 1; k < 20; k++) begin
      tick();
      hs_m[k] = !if_b.HSYN;
      hb_m[k] = !if_b.HBLK;
    end
  endtask

  task automatic wait_fs_c(output int n);
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (if_c.frame_start) begin
        n = i;
        return;
      end
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int ls_cnt, ls_pos0, ls_pos1, hblk_low, hsyn_low, hsyn_first, strobe_err, bad, n;
    int vs_low, vb_low, vs_k1, vs_k41;
    logic [19:0] hs_m, hb_m, hs_f1;

    vecs[0]  = '{1,     12'hABC, 497, 496, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[1]  = '{17,    12'hABC, 1,   496, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[2]  = '{6144,  12'hABC, 496, 0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000};
    vecs[3]  = '{6145,  12'hABC, 497, 0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[4]  = '{6160,  12'hABC, 0,   0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[5]  = '{6161,  12'hABC, 1,   0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'hABC};
    vecs[6]  = '{6416,  12'h123, 256, 0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h123};
    vecs[7]  = '{6417,  12'h123, 257, 0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[8]  = '{6456,  12'hABC, 296, 0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[9]  = '{6457,  12'hABC, 297, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    vecs[10] = '{6488,  12'hABC, 328, 0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000};
    vecs[11] = '{6489,  12'hABC, 329, 0,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    vecs[12] = '{38600, 12'hABC, 184, 84,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'hABC};

    if_a.ce_pix = 1'b1; if_a.h_adj = '0; if_a.v_adj = '0; if_a.iRGB = 12'hABC;
    if_b.ce_pix = 1'b0; if_b.h_adj = '0; if_b.v_adj = '0; if_b.iRGB = 12'h000;
    if_c.ce_pix = 1'b0; if_c.h_adj = '0; if_c.v_adj = '0; if_c.iRGB = 12'h000;

    // Reset state of the default-geometry instance
    tick(); tick();
    chk("rst_hblk", if_a.HBLK, 1);
    chk("rst_vblk", if_a.VBLK, 1);
    chk("rst_hsyn", if_a.HSYN, 1);
    chk("rst_vsyn", if_a.VSYN, 1);
    chk("rst_orgb", if_a.oRGB, 0);
    chk("rst_ls", if_a.line_start, 0);
    chk("rst_fs", if_a.frame_start, 0);
    chk("rst_hpos", if_a.HPOS, 496);
    chk("rst_vpos", if_a.VPOS, 496);
    chk("rst_field", if_a.field, 0);

    // ce_pix every second clock over two lines
    rst_a = 1'b1;
    ls_cnt = 0; ls_pos0 = 0; ls_pos1 = 0; hblk_low = 0; hsyn_low = 0; hsyn_first = -1; strobe_err = 0;
    for (int i = 1; i <= 768; i++) begin
      if_a.ce_pix = 1'b1;
      tick();
      if (if_a.line_start) begin
        if (ls_cnt == 0) ls_pos0 = i;
        else ls_pos1 = i;
        ls_cnt++;
      end
      if (i <= 384) begin
        if (!if_a.HBLK) hblk_low++;
        if (!if_a.HSYN) begin
          hsyn_low++;
          if (hsyn_first < 0) hsyn_first = int'(if_a.HPOS);
        end
      end
      if_a.ce_pix = 1'b0;
      tick();
      if (if_a.line_start || if_a.frame_start) strobe_err++;
    end
    chk("ce2_ls_count", ls_cnt, 2);
    chk("ce2_ls_first", ls_pos0, 384);
    chk("ce2_ls_period", ls_pos1 - ls_pos0, 384);
    chk("ce2_hblk_low", hblk_low, 256);
    chk("ce2_hsyn_low", hsyn_low, 32);
    chk("ce2_hsyn_first_hpos", hsyn_first, 297);
    chk("ce2_strobe_ce_low", strobe_err, 0);

    // Table-driven vectors with ce_pix held high from a fresh reset
    if_a.ce_pix = 1'b1;
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    cur = 0;
    for (int i = 0; i < 13; i++) begin
      if_a.iRGB = vecs[i].rgb;
      while (cur < vecs[i].t) begin
        tick();
        cur++;
      end
      chk($sformatf("v%0d_hpos", i), if_a.HPOS, vecs[i].hpos);
      chk($sformatf("v%0d_vpos", i), if_a.VPOS, vecs[i].vpos);
      chk($sformatf("v%0d_hblk", i), if_a.HBLK, vecs[i].hblk);
      chk($sformatf("v%0d_vblk", i), if_a.VBLK, vecs[i].vblk);
      chk($sformatf("v%0d_hsyn", i), if_a.HSYN, vecs[i].hsyn);
      chk($sformatf("v%0d_vsyn", i), if_a.VSYN, vecs[i].vsyn);
      chk($sformatf("v%0d_ls", i), if_a.line_start, vecs[i].ls);
      chk($sformatf("v%0d_fs", i), if_a.frame_start, 0);
      chk($sformatf("v%0d_orgb", i), if_a.oRGB, vecs[i].orgb);
    end

    // ce_pix low for 1000 clocks mid-active: everything frozen
    if_a.ce_pix = 1'b0;
    if_a.iRGB = 12'h555;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (if_a.HPOS != 9'd184 || if_a.VPOS != 9'd84 || if_a.oRGB != 12'hABC ||
          if_a.HSYN != 1'b1 || if_a.VSYN != 1'b1 || if_a.HBLK != 1'b0 ||
          if_a.VBLK != 1'b0 || if_a.line_start || if_a.frame_start) bad++;
    end
    chk("freeze_bad_cycles", bad, 0);
    chk("freeze_hpos", if_a.HPOS, 184);

    // Reset mid-line at hcnt=200, vcnt=100 with ce_pix high
    if_a.iRGB = 12'hABC;
    if_a.ce_pix = 1'b1;
    rst_a = 1'b0;
    tick();
    chk("mid_rst_hpos", if_a.HPOS, 496);
    chk("mid_rst_vpos", if_a.VPOS, 496);
    chk("mid_rst_hblk", if_a.HBLK, 1);
    chk("mid_rst_vblk", if_a.VBLK, 1);
    chk("mid_rst_hsyn", if_a.HSYN, 1);
    chk("mid_rst_orgb", if_a.oRGB, 0);
    chk("mid_rst_ls", if_a.line_start, 0);
    rst_a = 1'b1;
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      if (if_a.line_start) begin
        n = i;
        break;
      end
    end
    chk("mid_rst_first_ls", n, 384);

    // Reduced progressive geometry: adjust latching and wrapped sync windows
    if_b.ce_pix = 1'b1;
    tick();
    rst_b = 1'b1;
    if_b.h_adj = -4'sd8;
    if_b.v_adj = 3'sd3;
    wait_ls_b(n);
    chk("b_first_ls", n, 20);
    capture_line_b(hs_m, hb_m);
    chk("b_f0_hsyn_mask", int'(hs_m), 32'h70000);
    chk("b_f0_hblk_mask", int'(hb_m), 32'h07FF8);
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (if_b.frame_start) begin
        n = i;
        break;
      end
    end
    chk("b_f0_fs_seen", (n > 0) ? 1 : 0, 1);
    vs_low = 0; vb_low = 0; vs_k1 = -1; vs_k41 = -1; hs_f1 = '0; n = 0;
    for (int k = 1; k <= 400; k++) begin
      tick();
      if (k == 100) if_b.h_adj = 4'sd4;
      if (!if_b.VSYN) vs_low++;
      if (!if_b.VBLK) vb_low++;
      if (k == 1) vs_k1 = int'(if_b.VSYN);
      if (k == 41) vs_k41 = int'(if_b.VSYN);
      if (k >= 20 && k < 40) hs_f1[k-20] = !if_b.HSYN;
      if (if_b.frame_start) begin
        n = k;
        break;
      end
    end
    chk("b_frame_period", n, 200);
    chk("b_f1_hsyn_mask", int'(hs_f1), 32'h00700);
    chk("b_f1_vsyn_low", vs_low, 40);
    chk("b_f1_vsyn_k1", vs_k1, 0);
    chk("b_f1_vsyn_k41", vs_k41, 1);
    chk("b_f1_vblk_low", vb_low, 120);
    wait_ls_b(n);
    chk("b_f2_ls", n, 20);
    capture_line_b(hs_m, hb_m);
    chk("b_f2_hsyn_wrap_mask", int'(hs_m), 32'h00007);
    chk("b_field_const", if_b.field, 0);

    // Reduced interlaced geometry: alternating field lengths
    if_c.ce_pix = 1'b1;
    tick();
    rst_c = 1'b1;
    chk("c_rst_field", if_c.field, 0);
    wait_fs_c(n);
    chk("c_fs1_period", n, 200);
    chk("c_fs1_field", if_c.field, 1);
    wait_fs_c(n);
    chk("c_fs2_period", n, 220);
    chk("c_fs2_field", if_c.field, 0);
    wait_fs_c(n);
    chk("c_fs3_period", n, 200);
    chk("c_fs3_field", if_c.field, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
